i2c_dac_target_rx: RTL and testbench

- Receive-side counterpart of the team's bit-banged I2C DAC-write generator.
- Oversamples SCL/SDA on the fast system clock and decodes START/STOP conditions and bytes.
- Matches the device address, drives ACK through an open-drain enable, and presents the decoded DAC write (command, channel, 12-bit value) with a one-cycle valid strobe.
- Used as a bus-side DAC model and loopback checker on the board, and as the bench responder for the generator.

---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_dac_target_rx_if.sv | 28 ++
 rtl/i2c_line_filter.sv | 36 +++
 rtl/i2c_dac_target_rx.sv | 183 ++++++++++++++++++
 tb/tb_i2c_dac_target_rx.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C DAC-write target receiver.
// State encoding, byte geometry and default address.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ACK,
      DATA,
      IGNORE
   } state_t;

   localparam int         BYTE_BITS   = 8;
   localparam int         RW_BIT      = 0;
   localparam logic [5:0] ADDR_HI_DEF = 6'b100110;

endpackage

// File: rtl/i2c_dac_target_rx_if.sv
// Bus pins and decoded-frame outputs of the DAC target receiver.
// slave = receiver side, master = bus/stimulus side.
interface i2c_dac_target_rx_if;

   logic        scl_in;
   logic        sda_in;
   logic        chip_id;
   logic        sda_oe;
   logic        rx_valid;
   logic [3:0]  rx_cmd;
   logic [3:0]  rx_channel;
   logic [11:0] rx_value;
   logic        rx_error;
   logic        busy;

   modport slave (
      input  scl_in, sda_in, chip_id,
      output sda_oe, rx_valid, rx_cmd, rx_channel,
      output rx_value, rx_error, busy
   );

   modport master (
      output scl_in, sda_in, chip_id,
      input  sda_oe, rx_valid, rx_cmd, rx_channel,
      input  rx_value, rx_error, busy
   );

endinterface

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus a FILT_LEN-deep glitch filter for one pad.
// The filtered level idles high like a released open-drain line.
module i2c_line_filter #(
   parameter int FILT_LEN = 3
) (
   input  logic clk_in,
   input  logic reset_in,
   input  logic raw,
   output logic level
);

   logic [1:0] sync;
   logic [3:0] cnt;

   // bring the asynchronous pad into the clock domain
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) sync <= 2'b11;
      else          sync <= {sync[0], raw};
   end

   // only accept a new level after FILT_LEN equal samples in a row
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         level <= 1'b1;
         cnt   <= '0;
      end else if (sync[1] == level) begin
         cnt <= '0;
      end else if (cnt == 4'(FILT_LEN - 1)) begin
         level <= sync[1];
         cnt   <= '0;
      end else begin
         cnt <= cnt + 4'd1;
      end
   end

endmodule

// File: rtl/i2c_dac_target_rx.sv
// I2C target that decodes a DAC write frame: address, cmd/channel, 12-bit value.
// ACKs through an open-drain enable and flags short or overlong frames.
module i2c_dac_target_rx
   import i2c_pkg::*;
#(
   parameter logic [5:0] ADDR_HI  = ADDR_HI_DEF,
   parameter int         FILT_LEN = 3,
   parameter int         NUM_DATA = 3
) (
   input logic                clk_in,
   input logic                reset_in,
   i2c_dac_target_rx_if.slave bus
);

   localparam int BW = $clog2(BYTE_BITS);
   localparam int CW = $clog2(NUM_DATA + 1);

   logic          scl_f, sda_f, scl_d, sda_d;
   logic          scl_rise, scl_fall, start_ev, stop_ev, fin;
   state_t        state, state_nx;
   logic          ack_drv, ack_nx, ack_phase, phase_nx;
   logic          hit, store, ovf_set, byte_done, addr_ok;
   logic [7:0]    shift, shift_nx;
   logic [BW-1:0] bit_cnt;
   logic [CW-1:0] byte_cnt;
   logic          matched, ovf;
   logic [7:0]    hold [NUM_DATA];
   logic [3:0]    cmd_q, ch_q;
   logic [11:0]   val_q;
   logic          valid_q, err_q;
   logic          unused_lsb;

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .raw      (bus.scl_in),
      .level    (scl_f)
   );

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .raw      (bus.sda_in),
      .level    (sda_f)
   );

   // previous filtered levels for edge detection
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         scl_d <= 1'b1;
         sda_d <= 1'b1;
      end else begin
         scl_d <= scl_f;
         sda_d <= sda_f;
      end
   end

   assign scl_rise = scl_f & ~scl_d;
   assign scl_fall = ~scl_f & scl_d;
   assign start_ev = scl_f & scl_d & sda_d & ~sda_f;
   assign stop_ev  = scl_f & scl_d & ~sda_d & sda_f;
   assign fin      = start_ev | stop_ev;

   assign shift_nx  = {shift[6:0], sda_f};
   assign byte_done = scl_rise && (bit_cnt == BW'(BYTE_BITS - 1))
                      && (state == ADDR || state == DATA);
   assign addr_ok   = (shift_nx[7:1] == {ADDR_HI, bus.chip_id})
                      && !shift_nx[RW_BIT];

   // next state and ACK drive; bus conditions override bit handling
   always_comb begin
      state_nx = state;
      ack_nx   = ack_drv;
      phase_nx = ack_phase;
      hit      = 1'b0;
      store    = 1'b0;
      ovf_set  = 1'b0;
      if (fin) begin
         state_nx = start_ev ? ADDR : IDLE;
         ack_nx   = 1'b0;
         phase_nx = 1'b0;
      end else begin
         unique case (state)
            IDLE: ;
            ADDR: begin
               if (byte_done) begin
                  hit      = addr_ok;
                  state_nx = addr_ok ? ACK : IGNORE;
               end
            end
            ACK: begin
               if (scl_fall) begin
                  ack_nx   = !ack_phase;
                  phase_nx = !ack_phase;
                  if (ack_phase) state_nx = DATA;
               end
            end
            DATA: begin
               if (byte_done) begin
                  if (byte_cnt == CW'(NUM_DATA)) begin
                     ovf_set  = 1'b1;
                     state_nx = IGNORE;
                  end else begin
                     store    = 1'b1;
                     state_nx = ACK;
                  end
               end
            end
            IGNORE: ;
            default: state_nx = IDLE;
         endcase
      end
   end

   // state and ACK registers
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state     <= IDLE;
         ack_drv   <= 1'b0;
         ack_phase <= 1'b0;
      end else begin
         state     <= state_nx;
         ack_drv   <= ack_nx;
         ack_phase <= phase_nx;
      end
   end

   // byte assembly, frame bookkeeping and result outputs
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         shift    <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         matched  <= 1'b0;
         ovf      <= 1'b0;
         for (int i = 0; i < NUM_DATA; i++) hold[i] <= '0;
         cmd_q    <= '0;
         ch_q     <= '0;
         val_q    <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         valid_q <= fin && matched && !ovf
                    && byte_cnt == CW'(NUM_DATA);
         err_q   <= fin && matched
                    && (ovf || (byte_cnt != '0
                    && byte_cnt < CW'(NUM_DATA)));
         if (fin && matched && !ovf
             && byte_cnt == CW'(NUM_DATA)) begin
            cmd_q <= hold[0][7:4];
            ch_q  <= hold[0][3:0];
            val_q <= {hold[1], hold[2][7:4]};
         end
         if (fin) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            matched  <= 1'b0;
            ovf      <= 1'b0;
         end else begin
            if (scl_rise && (state == ADDR || state == DATA)) begin
               shift   <= shift_nx;
               bit_cnt <= bit_cnt + BW'(1);
            end
            if (hit) matched <= 1'b1;
            if (ovf_set) ovf <= 1'b1;
            if (store) begin
               hold[byte_cnt] <= shift_nx;
               byte_cnt       <= byte_cnt + CW'(1);
            end
         end
      end
   end

   assign unused_lsb     = ^hold[NUM_DATA-1][3:0];
   assign bus.sda_oe     = ack_drv & ~fin;
   assign bus.rx_valid   = valid_q;
   assign bus.rx_error   = err_q;
   assign bus.rx_cmd     = cmd_q;
   assign bus.rx_channel = ch_q;
   assign bus.rx_value   = val_q;
   assign bus.busy       = matched;

endmodule

// File: tb/tb_i2c_dac_target_rx.sv
// Bench for the I2C DAC target: bit-banged master, wired-AND SDA,
// scoreboard of expected valid/error pulses.
module tb_i2c_dac_target_rx;

   localparam logic [5:0] A_HI = 6'b100110;

   typedef struct packed {
      logic [1:0]  kind;
      logic [3:0]  cmd;
      logic [3:0]  ch;
      logic [11:0] val;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_in = 1'b1;
   logic        scl = 1'b1;
   logic        sda_m = 1'b1;
   logic        chip = 1'b1;
   int          checks = 0;
   int          errors = 0;
   int          hp = 8;
   bit          oe_seen = 1'b0;
   logic [3:0]  m_cmd = '0;
   logic [3:0]  m_ch = '0;
   logic [11:0] m_val = '0;
   exp_t        q[$];

   i2c_dac_target_rx_if bus_if ();

   assign bus_if.scl_in  = scl;
   assign bus_if.sda_in  = sda_m & ~bus_if.sda_oe;
   assign bus_if.chip_id = chip;

   i2c_dac_target_rx dut (
      .clk_in   (clk),
      .reset_in (reset_in),
      .bus      (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // scoreboard: every valid/error pulse must match the next expectation
   always @(negedge clk) begin
      exp_t e;
      if (!reset_in) begin
         if (bus_if.sda_oe) oe_seen = 1'b1;
         if (bus_if.rx_valid || bus_if.rx_error) begin
            if (q.size() == 0) begin
               check("spurious", 32'({bus_if.rx_valid, bus_if.rx_error}), 32'd0);
            end else begin
               e = q.pop_front();
               check("kind", 32'({bus_if.rx_valid, bus_if.rx_error}), 32'(e.kind));
               check("cmd", 32'(bus_if.rx_cmd), 32'(e.cmd));
               check("chan", 32'(bus_if.rx_channel), 32'(e.ch));
               check("value", 32'(bus_if.rx_value), 32'(e.val));
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      sda_m = b;
      tick(hp);
      scl = 1'b1;
      if (glitch) begin
         tick(3);
         sda_m = ~b;
         tick(1);
         sda_m = b;
         tick(hp - 4);
      end else begin
         tick(hp);
      end
      scl = 1'b0;
      tick(hp);
   endtask

   task automatic ack_clk(output logic a);
      sda_m = 1'b1;
      tick(hp);
      scl = 1'b1;
      tick(hp);
      a = bus_if.sda_oe;
      scl = 1'b0;
      tick(hp);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit glitch,
                            output logic a);
      for (int i = 7; i >= 0; i--) send_bit(b[i], glitch && i == 7);
      ack_clk(a);
   endtask

   task automatic do_start(input bit rs);
      if (rs) begin
         sda_m = 1'b1;
         tick(hp);
         scl = 1'b1;
         tick(hp);
      end
      sda_m = 1'b0;
      tick(hp);
      scl = 1'b0;
      tick(hp);
   endtask

   task automatic do_stop();
      sda_m = 1'b0;
      tick(hp);
      scl = 1'b1;
      tick(hp);
      sda_m = 1'b1;
      tick(hp);
   endtask

   // one frame: data holds up to four bytes, first byte in [31:24]
   task automatic frame(input logic [7:0] a, input int n,
                        input logic [31:0] data, input bit rs,
                        input bit stp, input bit glitch);
      logic       ack;
      logic       m;
      logic [7:0] d;
      exp_t       e;
      m = (a[7:1] == {A_HI, chip}) && !a[0];
      oe_seen = 1'b0;
      do_start(rs);
      send_byte(a, 1'b0, ack);
      check("ack_addr", 32'(ack), 32'(m));
      check("busy_addr", 32'(bus_if.busy), 32'(m));
      for (int i = 0; i < n; i++) begin
         d = data[31-8*i -: 8];
         send_byte(d, glitch && i == 0, ack);
         check("ack_data", 32'(ack), 32'(m && i < 3));
      end
      if (m && n == 3) begin
         m_cmd = data[31:28];
         m_ch  = data[27:24];
         m_val = data[23:12];
         e = '{kind: 2'b10, cmd: m_cmd, ch: m_ch, val: m_val};
         q.push_back(e);
      end else if (m && n > 0) begin
         e = '{kind: 2'b01, cmd: m_cmd, ch: m_ch, val: m_val};
         q.push_back(e);
      end
      if (stp) begin
         do_stop();
         tick(20);
         check("busy_stop", 32'(bus_if.busy), 32'd0);
      end
   endtask

   initial begin
      tick(4);
      reset_in = 1'b0;
      tick(4);
      check("rst_oe", 32'(bus_if.sda_oe), 32'd0);
      check("rst_valid", 32'(bus_if.rx_valid), 32'd0);
      check("rst_error", 32'(bus_if.rx_error), 32'd0);
      check("rst_busy", 32'(bus_if.busy), 32'd0);
      check("rst_cmd", 32'(bus_if.rx_cmd), 32'd0);
      check("rst_chan", 32'(bus_if.rx_channel), 32'd0);
      check("rst_value", 32'(bus_if.rx_value), 32'd0);

      frame(8'h9A, 3, 32'h3AABC000, 1'b0, 1'b1, 1'b0);
      check("f1_cmd", 32'(bus_if.rx_cmd), 32'h3);
      check("f1_chan", 32'(bus_if.rx_channel), 32'hA);
      check("f1_value", 32'(bus_if.rx_value), 32'hABC);

      chip = 1'b0;
      frame(8'h9A, 3, 32'h3AABC000, 1'b0, 1'b1, 1'b0);
      check("nomatch_oe", 32'(oe_seen), 32'd0);
      check("nomatch_keep", 32'(bus_if.rx_value), 32'(m_val));
      chip = 1'b1;

      frame(8'h9B, 0, 32'h0, 1'b0, 1'b0, 1'b0);
      frame(8'h9A, 3, 32'h01123000, 1'b1, 1'b1, 1'b0);
      check("rs_value", 32'(bus_if.rx_value), 32'h123);
      check("rs_chan", 32'(bus_if.rx_channel), 32'h1);

      frame(8'h9A, 2, 32'h55660000, 1'b0, 1'b1, 1'b0);
      check("short_keep", 32'(bus_if.rx_value), 32'h123);
      frame(8'h9A, 4, 32'h11223344, 1'b0, 1'b1, 1'b0);
      check("long_keep", 32'(bus_if.rx_value), 32'h123);

      frame(8'h9A, 3, 32'h5F9C7000, 1'b0, 1'b1, 1'b1);
      check("glitch_value", 32'(bus_if.rx_value), 32'h9C7);

      do_start(1'b0);
      for (int i = 7; i >= 0; i--) send_bit(8'h9A >> i, 1'b0);
      for (int i = 0; i < 50 && !bus_if.sda_oe; i++) tick(1);
      check("pre_rst_oe", 32'(bus_if.sda_oe), 32'd1);
      reset_in = 1'b1;
      #1;
      check("mid_rst_oe", 32'(bus_if.sda_oe), 32'd0);
      check("mid_rst_busy", 32'(bus_if.busy), 32'd0);
      check("mid_rst_value", 32'(bus_if.rx_value), 32'd0);
      check("mid_rst_cmd", 32'(bus_if.rx_cmd), 32'd0);
      check("mid_rst_chan", 32'(bus_if.rx_channel), 32'd0);
      tick(1);
      sda_m = 1'b1;
      tick(2);
      scl = 1'b1;
      tick(4);
      reset_in = 1'b0;
      m_cmd = '0;
      m_ch  = '0;
      m_val = '0;
      tick(10);

      hp = 20;
      frame(8'h9A, 3, 32'h327FF000, 1'b0, 1'b1, 1'b0);
      check("loop_value", 32'(bus_if.rx_value), 32'h7FF);
      check("loop_chan", 32'(bus_if.rx_channel), 32'h2);

      tick(20);
      check("pending", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
